// File: rtl/pulsar_call_pkg.sv
// Shared state encoding, default widths and a slot helper for the pulsar stream caller.
package pulsar_call_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 64;
    localparam int unsigned DEFAULT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALL  = 2'd1,
        DRAIN = 2'd2
    } call_state_e;

    // A single-entry slot can take a new value when empty or being emptied this cycle.
    function automatic logic slot_free(input logic valid, input logic ready);
        return ~valid | ready;
    endfunction

endpackage

// File: rtl/pulsar_stream_caller_if.sv
// Valid/ready stream carrying WIDTH-bit words; master produces, slave consumes.
interface pulsar_stream_caller_if #(
    parameter int unsigned WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pulsar_result_slot.sv
// Single-entry valid/ready holding register; a load wins over a same-cycle handshake.
module pulsar_result_slot
    import pulsar_call_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free_c
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign free_c    = slot_free(valid_q, out_ready);

endmodule

// File: rtl/pulsar_stream_caller.sv
// Launches one go/done callee invocation per streamed argument and presents the
// callee's return value on a valid/ready output stream.
module pulsar_stream_caller
    import pulsar_call_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    pulsar_stream_caller_if.slave  in_s,
    pulsar_stream_caller_if.master out_m,
    output logic                   callee_go,
    output logic [WIDTH-1:0]       callee_arg0,
    input  logic [WIDTH-1:0]       callee_ret,
    input  logic                   callee_done,
    output logic [CNT_WIDTH-1:0]   call_count,
    output logic                   busy
);

    call_state_e          state_q, state_d;
    logic [WIDTH-1:0]     arg_q, arg_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 load_c;
    logic                 slot_free_c;
    logic                 in_ready_c;
    logic                 go_c;
    logic                 slot_valid;
    logic [WIDTH-1:0]     slot_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            arg_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            count_q <= count_d;
        end
    end

    // go falls in the same cycle done is seen so the callee does not restart.
    always_comb begin
        state_d    = state_q;
        arg_d      = arg_q;
        count_d    = count_q;
        load_c     = 1'b0;
        in_ready_c = 1'b0;
        go_c       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_s.valid) begin
                    arg_d   = in_s.data;
                    state_d = CALL;
                end
            end
            CALL: begin
                go_c = ~callee_done;
                if (callee_done) begin
                    if (slot_free_c) begin
                        load_c  = 1'b1;
                        count_d = count_q + CNT_WIDTH'(1);
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // callee_ret stays put here because the callee is not re-issued go.
                if (slot_free_c) begin
                    load_c  = 1'b1;
                    count_d = count_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pulsar_result_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .load_data (callee_ret),
        .out_ready (out_m.ready),
        .out_valid (slot_valid),
        .out_data  (slot_data),
        .free_c    (slot_free_c)
    );

    assign in_s.ready  = in_ready_c;
    assign out_m.valid = slot_valid;
    assign out_m.data  = slot_data;
    assign callee_go   = go_c;
    assign callee_arg0 = arg_q;
    assign call_count  = count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pulsar_stream_caller.sv
// Self-checking bench for pulsar_stream_caller driving an increment callee model.
module tb_pulsar_stream_caller;

    localparam int unsigned W          = 64;
    localparam int unsigned CW         = 2;
    localparam int unsigned LAT        = 3;
    localparam int unsigned CLK_PERIOD = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          done;
    logic [W-1:0]  arg0;
    logic [W-1:0]  ret;
    logic [CW-1:0] call_count;
    logic          busy;

    pulsar_stream_caller_if #(.WIDTH(W)) in_if ();
    pulsar_stream_caller_if #(.WIDTH(W)) out_if ();

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          rd_idx       = 0;
    int unsigned calls_done   = 0;

    always #(CLK_PERIOD / 2) clk = ~clk;

    pulsar_stream_caller #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (rst),
        .in_s        (in_if),
        .out_m       (out_if),
        .callee_go   (go),
        .callee_arg0 (arg0),
        .callee_ret  (ret),
        .callee_done (done),
        .call_count  (call_count),
        .busy        (busy)
    );

    // Increment callee: done pulses once after LAT cycles of go, ret = arg0 + 1.
    int unsigned c_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_cnt <= 0;
            done  <= 1'b0;
            ret   <= '0;
        end else begin
            done <= 1'b0;
            if (go) begin
                if (c_cnt == LAT - 1) begin
                    c_cnt <= 0;
                    done  <= 1'b1;
                    ret   <= arg0 + W'(1);
                end else begin
                    c_cnt <= c_cnt + 1;
                end
            end
        end
    end

    // Output stream recorder plus protocol invariants.
    logic [W-1:0] got_q[$];
    int unsigned  overlap_cnt    = 0;
    int unsigned  ready_busy_err = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_if.valid && out_if.ready) got_q.push_back(out_if.data);
            if (go && done) overlap_cnt++;
            if (in_if.ready === busy) ready_busy_err++;
        end
    end

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic send(input logic [W-1:0] a, output bit ok, output time t_acc);
        ok = 1'b0;
        t_acc = 0;
        in_if.valid = 1'b1;
        in_if.data  = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_if.ready) begin ok = 1'b1; t_acc = $time; end
            @(posedge clk); #1;
            if (ok) break;
        end
        in_if.valid = 1'b0;
        in_if.data  = rnd64();
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (got_q.size() >= rd_idx + n) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        rd_idx     = got_q.size();
        calls_done = 0;
    endtask

    task automatic test_reset();
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (go !== 1'b0) begin tests_failed++; $display("FAIL reset_go: got %b want 0", go); end
        tests_run++; if (in_if.ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_if.ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (out_if.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_if.valid); end
        tests_run++; if (out_if.data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_if.data); end
        tests_run++; if (call_count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", call_count); end
        tests_run++; if (arg0 !== '0) begin tests_failed++; $display("FAIL reset_arg0: got %h want 0", arg0); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (in_if.ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: in_ready %b busy %b want 1 0", in_if.ready, busy); end
        @(posedge clk); #1;
        rd_idx     = got_q.size();
        calls_done = 0;
    endtask

    task automatic test_single_call();
        logic [6:1]    gv;
        logic [6:1]    vv;
        logic [W-1:0]  d5;
        logic [CW-1:0] c5;
        d5 = '0;
        c5 = '0;
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = W'(5);
        @(negedge clk);
        tests_run++; if (in_if.ready !== 1'b1) begin tests_failed++; $display("FAIL single_accept: in_ready %b want 1", in_if.ready); end
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            gv[k] = go;
            vv[k] = out_if.valid;
            if (k == 5) begin d5 = out_if.data; c5 = call_count; end
            @(posedge clk); #1;
        end
        tests_run++; if (gv !== 6'b000111) begin tests_failed++; $display("FAIL single_go_window: got %b want 000111", gv); end
        tests_run++; if (vv !== 6'b010000) begin tests_failed++; $display("FAIL single_valid_window: got %b want 010000", vv); end
        tests_run++; if (d5 !== W'(6)) begin tests_failed++; $display("FAIL single_data: got %0d want 6", d5); end
        calls_done++;
        tests_run++; if (c5 !== CW'(calls_done)) begin tests_failed++; $display("FAIL single_count: got %0d want %0d", c5, CW'(calls_done)); end
        rd_idx = got_q.size();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] args [3];
        logic [W-1:0] exps [3];
        time          t [3];
        bit           ok;
        args[0] = W'(0);  args[1] = W'(1);  args[2] = {W{1'b1}};
        exps[0] = W'(1);  exps[1] = W'(2);  exps[2] = W'(0);
        out_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(args[i], ok, t[i]);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_accept_%0d: timed out", i); end
        end
        for (int i = 1; i < 3; i++) begin
            tests_run++;
            if (t[i] - t[i-1] !== time'((LAT + 2) * CLK_PERIOD)) begin
                tests_failed++; $display("FAIL b2b_interval_%0d: got %0t want %0d", i, t[i] - t[i-1], (LAT + 2) * CLK_PERIOD);
            end
        end
        wait_results(3, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_results: timed out with %0d", got_q.size() - rd_idx); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                tests_run++; if (got_q[rd_idx + i] !== exps[i]) begin tests_failed++; $display("FAIL b2b_data_%0d: got %h want %h", i, got_q[rd_idx + i], exps[i]); end
            end
            rd_idx += 3;
        end
        calls_done += 3;
        tests_run++; if (call_count !== CW'(calls_done)) begin tests_failed++; $display("FAIL b2b_count: got %0d want %0d", call_count, CW'(calls_done)); end
    endtask

    task automatic test_backpressure();
        bit  ok;
        bit  stable;
        time t;
        int  seen;
        out_if.ready = 1'b0;
        send(W'(10), ok, t);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_accept_a: timed out"); end
        send(W'(20), ok, t);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_accept_b: timed out"); end
        seen = got_q.size();
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_if.valid !== 1'b1 || out_if.data !== W'(11)) stable = 1'b0;
            if (i == 7) begin
                tests_run++; if (go !== 1'b0 || busy !== 1'b1 || in_if.ready !== 1'b0) begin
                    tests_failed++; $display("FAIL bp_parked: go %b busy %b in_ready %b want 0 1 0", go, busy, in_if.ready);
                end
            end
            @(posedge clk); #1;
        end
        tests_run++; if (!stable) begin tests_failed++; $display("FAIL bp_hold: out_valid %b out_data %0d want 1 11", out_if.valid, out_if.data); end
        tests_run++; if (got_q.size() !== seen) begin tests_failed++; $display("FAIL bp_no_output: got %0d outputs want 0", got_q.size() - seen); end
        out_if.ready = 1'b1;
        wait_results(2, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_results: timed out"); end
        if (ok) begin
            tests_run++; if (got_q[rd_idx] !== W'(11)) begin tests_failed++; $display("FAIL bp_first: got %0d want 11", got_q[rd_idx]); end
            tests_run++; if (got_q[rd_idx + 1] !== W'(21)) begin tests_failed++; $display("FAIL bp_second: got %0d want 21", got_q[rd_idx + 1]); end
            rd_idx += 2;
        end
        calls_done += 2;
        tests_run++; if (call_count !== CW'(calls_done)) begin tests_failed++; $display("FAIL bp_count: got %0d want %0d", call_count, CW'(calls_done)); end
    endtask

    task automatic test_same_cycle();
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           ok;
        time          t;
        a = rnd64();
        b = rnd64();
        out_if.ready = 1'b0;
        send(a, ok, t);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL same_accept_a: timed out"); end
        idle_cycles(5);
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = b;
        @(negedge clk);
        tests_run++; if (in_if.ready !== 1'b1) begin tests_failed++; $display("FAIL same_in_ready: got %b want 1", in_if.ready); end
        tests_run++; if (out_if.valid !== 1'b1 || out_if.data !== a + W'(1)) begin
            tests_failed++; $display("FAIL same_pending: valid %b data %h want 1 %h", out_if.valid, out_if.data, a + W'(1));
        end
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        @(negedge clk);
        tests_run++; if (out_if.valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL same_both_taken: valid %b busy %b want 0 1", out_if.valid, busy); end
        @(posedge clk); #1;
        wait_results(2, ok);
        idle_cycles(4);
        tests_run++; if (got_q.size() !== rd_idx + 2) begin tests_failed++; $display("FAIL same_output_count: got %0d want 2", got_q.size() - rd_idx); end
        if (ok) begin
            tests_run++; if (got_q[rd_idx] !== a + W'(1)) begin tests_failed++; $display("FAIL same_first: got %h want %h", got_q[rd_idx], a + W'(1)); end
            tests_run++; if (got_q[rd_idx + 1] !== b + W'(1)) begin tests_failed++; $display("FAIL same_second: got %h want %h", got_q[rd_idx + 1], b + W'(1)); end
        end
        rd_idx = got_q.size();
        calls_done += 2;
        tests_run++; if (call_count !== CW'(calls_done)) begin tests_failed++; $display("FAIL same_count: got %0d want %0d", call_count, CW'(calls_done)); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q[$];
        logic [W-1:0] a;
        int           n_acc;
        bit           ok;
        n_acc = 0;
        a = rnd64();
        for (int c = 0; c < 3000 && n_acc < 20; c++) begin
            in_if.valid  = ($urandom_range(0, 3) != 0);
            in_if.data   = in_if.valid ? a : rnd64();
            out_if.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_if.valid && in_if.ready) begin
                exp_q.push_back(a + W'(1));
                n_acc++;
                a = rnd64();
            end
            @(posedge clk); #1;
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        tests_run++; if (n_acc != 20) begin tests_failed++; $display("FAIL rand_accepts: got %0d want 20", n_acc); end
        wait_results(n_acc, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_results: got %0d want %0d", got_q.size() - rd_idx, n_acc); end
        if (ok) begin
            for (int i = 0; i < n_acc; i++) begin
                tests_run++; if (got_q[rd_idx + i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_data_%0d: got %h want %h", i, got_q[rd_idx + i], exp_q[i]); end
            end
        end
        idle_cycles(2);
        rd_idx = got_q.size();
        calls_done += 32'(n_acc);
        tests_run++; if (call_count !== CW'(calls_done)) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", call_count, CW'(calls_done)); end
    endtask

    task automatic test_reset_mid_call();
        bit  ok;
        time t;
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = rnd64();
        @(negedge clk);
        tests_run++; if (in_if.ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_accept: in_ready %b want 1", in_if.ready); end
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        idle_cycles(2);
        tests_run++; if (go !== 1'b1) begin tests_failed++; $display("FAIL midrst_go_before: got %b want 1", go); end
        rst = 1'b1;
        #1;
        tests_run++; if (go !== 1'b0) begin tests_failed++; $display("FAIL midrst_go: got %b want 0", go); end
        tests_run++; if (out_if.valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b want 0", out_if.valid); end
        tests_run++; if (call_count !== '0) begin tests_failed++; $display("FAIL midrst_count: got %0d want 0", call_count); end
        idle_cycles(2);
        rst = 1'b0;
        rd_idx     = got_q.size();
        calls_done = 0;
        idle_cycles(6);
        tests_run++; if (got_q.size() !== rd_idx || call_count !== '0) begin
            tests_failed++; $display("FAIL midrst_discard: outputs %0d count %0d want 0 0", got_q.size() - rd_idx, call_count);
        end
        send(W'(7), ok, t);
        wait_results(1, ok);
        tests_run++; if (!ok || got_q[rd_idx] !== W'(8)) begin tests_failed++; $display("FAIL midrst_next: got %0d want 8", ok ? got_q[rd_idx] : '0); end
        rd_idx = got_q.size();
        calls_done++;
        tests_run++; if (call_count !== CW'(calls_done)) begin tests_failed++; $display("FAIL midrst_next_count: got %0d want %0d", call_count, CW'(calls_done)); end
    endtask

    task automatic test_counter_wrap();
        logic [CW-1:0] exp_cnt [5];
        logic [W-1:0]  a;
        bit            ok;
        time           t;
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
        do_reset();
        out_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = rnd64();
            send(a, ok, t);
            wait_results(1, ok);
            tests_run++; if (!ok || got_q[rd_idx] !== a + W'(1)) begin tests_failed++; $display("FAIL wrap_data_%0d: got %h want %h", i, ok ? got_q[rd_idx] : '0, a + W'(1)); end
            rd_idx = got_q.size();
            tests_run++; if (call_count !== exp_cnt[i]) begin tests_failed++; $display("FAIL wrap_count_%0d: got %0d want %0d", i, call_count, exp_cnt[i]); end
        end
    endtask

    initial begin
        #(CLK_PERIOD * 40000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        #2;
        test_reset();
        test_single_call();
        test_back_to_back();
        test_backpressure();
        test_same_cycle();
        test_random();
        test_reset_mid_call();
        test_counter_wrap();
        tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("FAIL go_with_done: got %0d cycles want 0", overlap_cnt); end
        tests_run++; if (ready_busy_err != 0) begin tests_failed++; $display("FAIL in_ready_vs_busy: got %0d cycles want 0", ready_busy_err); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
